// File: rtl/alu_issue_sched.sv
// alu_issue_sched: round-robin issue arbiter with register scoreboard in front of the shared ALU
module alu_issue_sched #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32,
    localparam int REG_W   = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [1:0]                  req_valid_i,
    output logic [1:0]                  req_ready_o,
    input  logic [1:0][1:0]             req_opcode_i,
    input  logic [1:0]                  req_font_i,
    input  logic [1:0][REG_W-1:0]       req_src1_i,
    input  logic [1:0][REG_W-1:0]       req_src2_i,
    input  logic [1:0][REG_W-1:0]       req_dst_i,
    input  logic [1:0]                  req_wb_wr_i,
    input  logic [1:0][DATA_W-1:0]      req_imm_i,
    output logic                        iss_valid_o,
    output logic [1:0]                  iss_opcode_o,
    output logic                        iss_font_o,
    output logic [REG_W-1:0]            iss_src1_o,
    output logic [REG_W-1:0]            iss_src2_o,
    output logic [REG_W-1:0]            iss_dst_o,
    output logic                        iss_wb_wr_o,
    output logic [DATA_W-1:0]           iss_imm_o,
    output logic                        iss_id_o,
    input  logic                        wb_valid_i,
    input  logic [REG_W-1:0]            wb_reg_i,
    input  logic                        flush_i,
    output logic [NUM_REGS-1:0]         busy_o,
    output logic                        idle_o
);
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [REG_W:0]      out_q, out_d;
    logic                last_q, last_d;
    logic                iss_valid_q, iss_valid_d;
    logic [1:0]          iss_opcode_q, iss_opcode_d;
    logic                iss_font_q, iss_font_d;
    logic [REG_W-1:0]    iss_src1_q, iss_src1_d;
    logic [REG_W-1:0]    iss_src2_q, iss_src2_d;
    logic [REG_W-1:0]    iss_dst_q, iss_dst_d;
    logic                iss_wb_wr_q, iss_wb_wr_d;
    logic [DATA_W-1:0]   iss_imm_q, iss_imm_d;
    logic                iss_id_q, iss_id_d;
    logic [1:0]          elig;
    logic                gnt, gnt_id, set_busy, wb_hit;

    // hazard check, round-robin grant and next-state of scoreboard and issue packet
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_valid_i[i]
                && !(req_opcode_i[i] != 2'd0 && !req_font_i[i] && busy_q[req_src1_i[i]])
                && !(req_opcode_i[i] == 2'd2 && busy_q[req_src2_i[i]])
                && !(req_wb_wr_i[i] && busy_q[req_dst_i[i]]);
        end
        gnt = |elig && !flush_i && !arst;
        gnt_id = (elig[0] && elig[1]) ? ~last_q : elig[1];
        req_ready_o = gnt ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
        set_busy = gnt && req_wb_wr_i[gnt_id];
        wb_hit = wb_valid_i && busy_q[wb_reg_i];
        busy_d = busy_q;
        if (wb_valid_i) busy_d[wb_reg_i] = 1'b0;
        if (set_busy) busy_d[req_dst_i[gnt_id]] = 1'b1;
        out_d = out_q + (REG_W+1)'(set_busy) - (REG_W+1)'(wb_hit);
        if (flush_i) begin
            busy_d = '0;
            out_d = '0;
        end
        last_d = gnt ? gnt_id : last_q;
        iss_valid_d = gnt;
        iss_opcode_d = gnt ? req_opcode_i[gnt_id] : iss_opcode_q;
        iss_font_d = gnt ? req_font_i[gnt_id] : iss_font_q;
        iss_src1_d = gnt ? req_src1_i[gnt_id] : iss_src1_q;
        iss_src2_d = gnt ? req_src2_i[gnt_id] : iss_src2_q;
        iss_dst_d = gnt ? req_dst_i[gnt_id] : iss_dst_q;
        iss_wb_wr_d = gnt ? req_wb_wr_i[gnt_id] : iss_wb_wr_q;
        iss_imm_d = gnt ? req_imm_i[gnt_id] : iss_imm_q;
        iss_id_d = gnt ? gnt_id : iss_id_q;
    end

    // state registers; reset leaves requester 0 first in line
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            busy_q       <= '0;
            out_q        <= '0;
            last_q       <= 1'b1;
            iss_valid_q  <= 1'b0;
            iss_opcode_q <= '0;
            iss_font_q   <= 1'b0;
            iss_src1_q   <= '0;
            iss_src2_q   <= '0;
            iss_dst_q    <= '0;
            iss_wb_wr_q  <= 1'b0;
            iss_imm_q    <= '0;
            iss_id_q     <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            out_q        <= out_d;
            last_q       <= last_d;
            iss_valid_q  <= iss_valid_d;
            iss_opcode_q <= iss_opcode_d;
            iss_font_q   <= iss_font_d;
            iss_src1_q   <= iss_src1_d;
            iss_src2_q   <= iss_src2_d;
            iss_dst_q    <= iss_dst_d;
            iss_wb_wr_q  <= iss_wb_wr_d;
            iss_imm_q    <= iss_imm_d;
            iss_id_q     <= iss_id_d;
        end
    end

    assign iss_valid_o  = iss_valid_q;
    assign iss_opcode_o = iss_opcode_q;
    assign iss_font_o   = iss_font_q;
    assign iss_src1_o   = iss_src1_q;
    assign iss_src2_o   = iss_src2_q;
    assign iss_dst_o    = iss_dst_q;
    assign iss_wb_wr_o  = iss_wb_wr_q;
    assign iss_imm_o    = iss_imm_q;
    assign iss_id_o     = iss_id_q;
    assign busy_o       = busy_q;
    assign idle_o       = (out_q == '0) && !iss_valid_q;
endmodule
